imem_fetch_port: RTL

Parametrised, pipelined instruction memory for the fetch stage of the 5-stage RISC-V core. Accepts fetch requests over a valid/ready handshake, performs a registered (synchronous) word read, and returns instruction, address and error status over a second valid/ready handshake. A 1-entry skid register sustains one fetch per cycle under back-pressure. A flush input discards stale responses on a PC redirect.

---
 rtl/imem_pkg.sv | 20 ++
 rtl/imem_skid_buf.sv | 67 ++++++
 rtl/imem_fetch_port.sv | 75 +++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory fetch port: default NOP word,
// index-width helper and the response layout {data, addr, err}.
package imem_pkg;

  // addi x0, x0, 0 -- handed back on any fetch that cannot be served
  localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0013;

  // Word-index width for a given depth (at least one bit)
  function automatic int imem_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Response payload for the default 32-bit address/data build
  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
    logic        err;
  } imem_rsp_t;

endpackage

// File: rtl/imem_skid_buf.sv
// Two-slot response buffer: OUT is what the consumer sees, SKID catches the
// one read already in flight when OUT stalls. Flush empties both slots but
// lets a same-cycle accept through, so a redirect PC can ride with the flush.
module imem_skid_buf #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic         skid_valid, skid_valid_n, out_valid_n;
  logic [W-1:0] skid_data, skid_data_n, out_data_n;
  logic         pop, acc;

  assign pop = out_valid && out_ready;
  assign acc = in_valid && in_ready;

  // Drain (flush or pop) first, then drop the accepted read into the first free slot
  always_comb begin
    out_valid_n  = out_valid;
    out_data_n   = out_data;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    if (flush) begin
      out_valid_n  = 1'b0;
      skid_valid_n = 1'b0;
    end else if (pop) begin
      out_valid_n  = skid_valid;
      skid_valid_n = 1'b0;
      if (skid_valid) out_data_n = skid_data;
    end
    if (acc) begin
      if (!out_valid_n) begin
        out_valid_n = 1'b1;
        out_data_n  = in_data;
      end else begin
        skid_valid_n = 1'b1;
        skid_data_n  = in_data;
      end
    end
  end

  // Slot registers; ready comes from the next SKID state so rsp_ready never reaches it combinationally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      in_ready   <= 1'b0;
    end else begin
      out_valid  <= out_valid_n;
      out_data   <= out_data_n;
      skid_valid <= skid_valid_n;
      skid_data  <= skid_data_n;
      in_ready   <= !skid_valid_n;
    end
  end

endmodule

// File: rtl/imem_fetch_port.sv
// Instruction memory with valid/ready fetch port. The word read is captured
// straight into the response buffer, giving one cycle of latency.
// Optional feature macro: IMEM_LOAD_EN adds the ld_* program-load write port;
// without it the memory is read-only.
module imem_fetch_port
  import imem_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 1024,
  parameter string             INIT_FILE = "instructions.hex",
  parameter logic [DATA_W-1:0] NOP_WORD  = IMEM_NOP_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err
`ifdef IMEM_LOAD_EN
  ,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
`endif
);

  localparam int IDX_W = imem_idx_w(DEPTH);
  localparam int PW    = DATA_W + ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              rd_err;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_data;
  logic [PW-1:0]     rd_pay, out_pay;

  // Misaligned or past-the-end fetches return a NOP; the truncated index keeps the array access in range
  assign rd_idx  = req_addr[2 +: IDX_W];
  assign rd_err  = (req_addr[1:0] != 2'b00) ||
                   ({2'b00, req_addr[ADDR_W-1:2]} >= ADDR_W'(DEPTH));
  assign rd_data = rd_err ? NOP_WORD : mem[rd_idx];
  assign rd_pay  = {rd_data, req_addr, rd_err};

`ifdef IMEM_LOAD_EN
  logic ld_ok;
  assign ld_ok = ld_we && (ld_addr[1:0] == 2'b00) &&
                 ({2'b00, ld_addr[ADDR_W-1:2]} < ADDR_W'(DEPTH));

  // Program-load write; the fetch path samples the old word on a same-cycle collision
  always_ff @(posedge clk) begin
    if (ld_ok) mem[ld_addr[2 +: IDX_W]] <= ld_data;
  end
`endif

  imem_skid_buf #(.W(PW)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (req_valid),
    .in_data   (rd_pay),
    .in_ready  (req_ready),
    .out_valid (rsp_valid),
    .out_data  (out_pay),
    .out_ready (rsp_ready)
  );

  assign {rsp_data, rsp_addr, rsp_err} = out_pay;

endmodule
